ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-client round-robin arbiter that acts as the initiator on the ram block's port set: it drives RD_EN/WR_EN/RD_ADDR/WR_ADDR/WR_DATA and consumes RD_DATA.
- Holds off all traffic until the RAM's post-reset clearing sweep is complete.
- Serialises client A and client B requests into at most one RAM operation per cycle.
- Returns read data to the requesting client with a valid strobe.

Parameters:
- G_ADDR_WIDTH, 4, address width; must match the RAM.
- G_DATA_WIDTH, 8, data width; must match the RAM.
- G_INIT_CYCLES, 2**G_ADDR_WIDTH+2, cycles after reset release before the first grant.

Ports:
- CLOCK  in  1  single clock; all logic on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- A_REQ  in  1  client A request; held with fields stable until A_GNT.
- A_WE  in  1  1 = write, 0 = read.
- A_ADDR  in  G_ADDR_WIDTH  client A address.
- A_WDATA  in  G_DATA_WIDTH  client A write data.
- A_GNT  out  1  one-cycle pulse: request accepted.
- A_RVALID  out  1  one-cycle pulse: A_RDATA valid.
- A_RDATA  out  G_DATA_WIDTH  read data for client A.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_GNT, B_RVALID, B_RDATA: same as the A ports, for client B.
- RAM_RD_EN  out  1  drives RAM RD_EN.
- RAM_WR_EN  out  1  drives RAM WR_EN.
- RAM_RD_ADDR  out  G_ADDR_WIDTH  drives RAM RD_ADDR.
- RAM_WR_ADDR  out  G_ADDR_WIDTH  drives RAM WR_ADDR.
- RAM_WR_DATA  out  G_DATA_WIDTH  drives RAM WR_DATA.
- RAM_RD_DATA  in  G_DATA_WIDTH  from RAM RD_DATA.
- READY  out  1  high once the init wait has ended.

Behaviour:
- Reset: RST_N low immediately clears every registered output (GNTs, RVALIDs, RAM_* enables/addresses/data, READY) to 0. Init counter returns to 0, FSM returns to INIT, and the round-robin pointer is set to A.
- RAM connection: the RAM needs one cycle with RST_N low to start its clearing sweep. The arbiter and RAM share RST_N; the arbiter's reset is async, but the RAM's reset is sampled on CLOCK.
- FSM states:
  - INIT: counter increments each cycle; on reaching G_INIT_CYCLES-1, go to RUN and set READY=1 the following cycle.
  - RUN: arbitrate every cycle.
  - No other states.
- Arbitration, cycle N (RUN):
  - Eligible client = REQ high AND its GNT not high in cycle N. The mask prevents double-grant of a request still held in the pulse cycle.
  - If both are eligible, pick the client indicated by the pointer; the pointer then moves to the other client.
  - If one is eligible, grant it; the pointer moves to the other client.
- Issue, cycle N+1 (all registered):
  - Winner's GNT=1.
  - Write: RAM_WR_EN=1, RAM_WR_ADDR/RAM_WR_DATA = winner's fields.
  - Read: RAM_RD_EN=1, RAM_RD_ADDR = winner's address.
  - The unused enable is 0; enables are 0 when there is no grant.
  - Address/data outputs hold their last value when idle.
- Read return, cycle N+2:
  - Requesting client's RVALID=1.
  - Its RDATA = RAM_RD_DATA, passed through combinationally. RDATA is a don't-care when RVALID=0; both RDATA buses may mirror RAM_RD_DATA.
  - A one-entry tag pipeline (valid + client id) tracks the return.
- Latency: GNT 1 cycle after request sampled; read data 2 cycles after sampling.
- Throughput:
  - 1 op/cycle total with both clients active (alternating A/B).
  - 1 op per 2 cycles for a single client holding REQ continuously.
- Ordering: ops reach the RAM in grant order. A read granted after a write to the same address returns the new data; the RAM commits the write on the edge before the read samples.
- Simultaneous read and write: never issued in the same cycle.
- Requests in INIT: ignored, no GNT; clients keep REQ asserted.
- Reset mid-operation: an in-flight RVALID is dropped (no pulse after reset). The client must re-request after READY.
- Write collisions and address wrap-around are not applicable; addresses pass through unmodified.

Decomposition:
- Shared package ram_pkg:
  - Default address/data widths.
  - Client-id constants: CLIENT_A=0, CLIENT_B=1.
  - FSM state encoding: INIT, RUN.
  - Init-cycle function 2**aw+2.
- Sub-module rr_arb2: 2-request round-robin picker with pointer register and grant-mask inputs. It is the only natural split; the rest stays in ram_arbiter.

Test Plan:
- Init hold: release reset, A_REQ write addr 3 data 0x5A from cycle 0 -> no A_GNT before cycle 18 (AW=4); GNT in the first cycle after READY; RAM_WR_EN pulses once with addr 3, data 0x5A.
- Read-back: A writes 0x5A to addr 3, then reads addr 3 -> A_RVALID exactly 2 cycles after the read request is sampled; A_RDATA=0x5A; B_RVALID stays 0.
- Contention: A and B both hold REQ (A writes 0x11@1, B writes 0x22@2) -> A granted first (pointer reset), B next cycle; RAM_WR_EN high two consecutive cycles.
- Fairness: A and B each hold reads continuously for 10 cycles -> GNTs alternate A,B,A,B; no client granted twice in a row; no double-grant within a pulse cycle.
- Single client back-to-back: B issues 4 reads with REQ held high -> one B_GNT every 2 cycles; 4 B_RVALID pulses, in order.
- Async reset mid-read: assert RST_N low between B_GNT and B_RVALID -> all outputs 0 immediately; no B_RVALID afterwards; READY returns after G_INIT_CYCLES.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the RAM arbiter: default widths, client ids,
// FSM state encoding and the post-reset wait length.
package ram_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    // Client ids; also the bit index of each client in grant/request vectors
    localparam logic CLIENT_A = 1'b0;
    localparam logic CLIENT_B = 1'b1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    // The RAM clears one word per cycle after reset; wait for the whole
    // sweep plus two cycles of margin before the first grant.
    function automatic int init_cycles(input int aw);
        return (1 << aw) + 2;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. A request is eligible only while its
// mask bit is low, so a request still held during its grant pulse is not
// granted a second time. The pointer names the client that wins a tie and
// always moves to the client that did not win.
module rr_arb2
    import ram_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] grant
);

    logic       ptr;
    logic [1:0] elig;

    // Pick at most one eligible request; the pointer breaks ties
    always_comb begin
        elig  = req & ~mask;
        grant = 2'b00;
        if (enable) begin
            if (elig[0] && elig[1]) begin
                grant = (ptr == CLIENT_B) ? 2'b10 : 2'b01;
            end else begin
                grant = elig;
            end
        end
    end

    // Hand priority to the other client after every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= CLIENT_A;
        end else if (grant[0]) begin
            ptr <= CLIENT_B;
        end else if (grant[1]) begin
            ptr <= CLIENT_A;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-client round-robin front end for the synchronous RAM. Waits out the
// RAM's clearing sweep after reset, then issues at most one registered RAM
// operation per cycle and routes read data back with a valid pulse.
//
// Handshake: a client raises REQ with WE/ADDR/WDATA stable and holds them
// until it sees its one-cycle GNT pulse (the cycle the RAM operation is
// presented). REQ has no ready; GNT is the acceptance. For a read, RVALID
// pulses one cycle after GNT, and RDATA is only meaningful in that cycle.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int G_ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int G_DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int G_INIT_CYCLES = init_cycles(G_ADDR_WIDTH)
) (
    input  logic                    CLOCK,
    input  logic                    RST_N,
    input  logic                    A_REQ,
    input  logic                    A_WE,
    input  logic [G_ADDR_WIDTH-1:0] A_ADDR,
    input  logic [G_DATA_WIDTH-1:0] A_WDATA,
    output logic                    A_GNT,
    output logic                    A_RVALID,
    output logic [G_DATA_WIDTH-1:0] A_RDATA,
    input  logic                    B_REQ,
    input  logic                    B_WE,
    input  logic [G_ADDR_WIDTH-1:0] B_ADDR,
    input  logic [G_DATA_WIDTH-1:0] B_WDATA,
    output logic                    B_GNT,
    output logic                    B_RVALID,
    output logic [G_DATA_WIDTH-1:0] B_RDATA,
    output logic                    RAM_RD_EN,
    output logic                    RAM_WR_EN,
    output logic [G_ADDR_WIDTH-1:0] RAM_RD_ADDR,
    output logic [G_ADDR_WIDTH-1:0] RAM_WR_ADDR,
    output logic [G_DATA_WIDTH-1:0] RAM_WR_DATA,
    input  logic [G_DATA_WIDTH-1:0] RAM_RD_DATA,
    output logic                    READY,
    output logic                    DBG_STATE
);

    localparam int CW = $clog2(G_INIT_CYCLES + 1);

    arb_state_t              state;
    logic [CW-1:0]           init_cnt;
    logic [1:0]              grant;
    logic                    any_grant;
    logic                    win_id;
    logic                    win_we;
    logic [G_ADDR_WIDTH-1:0] win_addr;
    logic [G_DATA_WIDTH-1:0] win_wdata;
    logic                    tag_valid;
    logic                    tag_id;

    rr_arb2 u_rr_arb2 (
        .clk    (CLOCK),
        .rst_n  (RST_N),
        .enable (state == RUN),
        .req    ({B_REQ, A_REQ}),
        .mask   ({B_GNT, A_GNT}),
        .grant  (grant)
    );

    // Winner's request fields
    assign any_grant = grant[0] | grant[1];
    assign win_id    = grant[1] ? CLIENT_B : CLIENT_A;
    assign win_we    = grant[1] ? B_WE    : A_WE;
    assign win_addr  = grant[1] ? B_ADDR  : A_ADDR;
    assign win_wdata = grant[1] ? B_WDATA : A_WDATA;

    // Read data comes straight from the RAM; RVALID qualifies it
    assign A_RDATA   = RAM_RD_DATA;
    assign B_RDATA   = RAM_RD_DATA;
    assign DBG_STATE = state;

    // Init wait: count out the RAM clearing sweep, then arbitrate forever
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= INIT;
            init_cnt <= '0;
            READY    <= 1'b0;
        end else if (state == INIT) begin
            if (init_cnt == CW'(G_INIT_CYCLES - 1)) begin
                state <= RUN;
                READY <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Issue the granted operation to the RAM and record who owns a read
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            A_GNT       <= 1'b0;
            B_GNT       <= 1'b0;
            RAM_RD_EN   <= 1'b0;
            RAM_WR_EN   <= 1'b0;
            RAM_RD_ADDR <= '0;
            RAM_WR_ADDR <= '0;
            RAM_WR_DATA <= '0;
            tag_valid   <= 1'b0;
            tag_id      <= CLIENT_A;
        end else begin
            A_GNT     <= grant[0];
            B_GNT     <= grant[1];
            RAM_WR_EN <= any_grant & win_we;
            RAM_RD_EN <= any_grant & ~win_we;
            tag_valid <= any_grant & ~win_we;
            if (any_grant) begin
                tag_id <= win_id;
            end
            if (any_grant && win_we) begin
                RAM_WR_ADDR <= win_addr;
                RAM_WR_DATA <= win_wdata;
            end
            if (any_grant && !win_we) begin
                RAM_RD_ADDR <= win_addr;
            end
        end
    end

    // Pulse RVALID to the owner of the read the RAM just answered
    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
        end else begin
            A_RVALID <= tag_valid & (tag_id == CLIENT_A);
            B_RVALID <= tag_valid & (tag_id == CLIENT_B);
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          CLOCK;
  logic          RST_N;
  logic          A_REQ, A_WE, A_GNT, A_RVALID;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_WDATA, A_RDATA;
  logic          B_REQ, B_WE, B_GNT, B_RVALID;
  logic [AW-1:0] B_ADDR;
  logic [DW-1:0] B_WDATA, B_RDATA;
  logic          RAM_RD_EN, RAM_WR_EN;
  logic [AW-1:0] RAM_RD_ADDR, RAM_WR_ADDR;
  logic [DW-1:0] RAM_WR_DATA, RAM_RD_DATA;
  logic          READY, DBG_STATE;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem [16];

  ram_arbiter #(.G_ADDR_WIDTH(AW), .G_DATA_WIDTH(DW)) dut (
    .CLOCK(CLOCK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .RAM_RD_EN(RAM_RD_EN), .RAM_WR_EN(RAM_WR_EN),
    .RAM_RD_ADDR(RAM_RD_ADDR), .RAM_WR_ADDR(RAM_WR_ADDR),
    .RAM_WR_DATA(RAM_WR_DATA), .RAM_RD_DATA(RAM_RD_DATA),
    .READY(READY), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // behavioural RAM: synchronous reset clear, one-cycle read latency
  always @(posedge CLOCK) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      RAM_RD_DATA <= '0;
    end else begin
      if (RAM_WR_EN) mem[RAM_WR_ADDR] <= RAM_WR_DATA;
      if (RAM_RD_EN) RAM_RD_DATA <= mem[RAM_RD_ADDR];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle_clients();
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_WDATA = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0;
  endtask

  task automatic apply_reset();
    idle_clients();
    RST_N = 0;
    tick();
    tick();
    RST_N = 1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && READY !== 1'b1; k++) tick();
    total++;
    if (READY !== 1'b1) begin
      bad++; $display("FAIL wait_ready: READY=%b required 1 within 40 cycles", READY);
    end
  endtask

  task automatic test_reset();
    idle_clients();
    RST_N = 0;
    #3;
    total++;
    if ({A_GNT, B_GNT, A_RVALID, B_RVALID, RAM_RD_EN, RAM_WR_EN, READY, DBG_STATE} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl: got %b required 00000000",
        {A_GNT, B_GNT, A_RVALID, B_RVALID, RAM_RD_EN, RAM_WR_EN, READY, DBG_STATE});
    end
    total++;
    if ({RAM_RD_ADDR, RAM_WR_ADDR, RAM_WR_DATA} !== 16'h0000) begin
      bad++; $display("FAIL reset_bus: got %h required 0000", {RAM_RD_ADDR, RAM_WR_ADDR, RAM_WR_DATA});
    end
  endtask

  task automatic test_init_hold();
    int wr_cnt = 0;
    apply_reset();
    A_REQ = 1; A_WE = 1; A_ADDR = 4'd3; A_WDATA = 8'h5A;
    for (int k = 1; k <= 18; k++) begin
      tick();
      total++;
      if (A_GNT !== 1'b0) begin
        bad++; $display("FAIL init_no_gnt: cycle %0d A_GNT=%b required 0", k, A_GNT);
      end
      if (RAM_WR_EN === 1'b1) wr_cnt++;
      if (k == 17) begin
        total++;
        if (READY !== 1'b0) begin
          bad++; $display("FAIL init_ready_early: cycle 17 READY=%b required 0", READY);
        end
      end
    end
    total++;
    if (READY !== 1'b1 || DBG_STATE !== 1'b1) begin
      bad++; $display("FAIL init_ready: READY=%b state=%b required 1 1", READY, DBG_STATE);
    end
    tick();
    total++;
    if (A_GNT !== 1'b1 || RAM_WR_EN !== 1'b1 || RAM_RD_EN !== 1'b0) begin
      bad++; $display("FAIL init_first_gnt: gnt=%b wr=%b rd=%b required 1 1 0", A_GNT, RAM_WR_EN, RAM_RD_EN);
    end
    total++;
    if (RAM_WR_ADDR !== 4'd3 || RAM_WR_DATA !== 8'h5A) begin
      bad++; $display("FAIL init_wr_fields: addr=%h data=%h required 3 5a", RAM_WR_ADDR, RAM_WR_DATA);
    end
    A_REQ = 0;
    tick();
    total++;
    if (A_GNT !== 1'b0 || RAM_WR_EN !== 1'b0 || wr_cnt != 0) begin
      bad++; $display("FAIL init_single_wr: gnt=%b wr=%b early_wr=%0d required 0 0 0", A_GNT, RAM_WR_EN, wr_cnt);
    end
  endtask

  task automatic test_read_back();
    A_REQ = 1; A_WE = 0; A_ADDR = 4'd3;
    tick();
    total++;
    if (A_GNT !== 1'b1 || RAM_RD_EN !== 1'b1 || RAM_WR_EN !== 1'b0 || RAM_RD_ADDR !== 4'd3) begin
      bad++; $display("FAIL rb_issue: gnt=%b rd=%b wr=%b addr=%h required 1 1 0 3",
        A_GNT, RAM_RD_EN, RAM_WR_EN, RAM_RD_ADDR);
    end
    total++;
    if (A_RVALID !== 1'b0) begin
      bad++; $display("FAIL rb_early_valid: A_RVALID=%b required 0", A_RVALID);
    end
    A_REQ = 0;
    tick();
    total++;
    if (A_RVALID !== 1'b1 || B_RVALID !== 1'b0 || A_RDATA !== 8'h5A) begin
      bad++; $display("FAIL rb_return: a_v=%b b_v=%b data=%h required 1 0 5a", A_RVALID, B_RVALID, A_RDATA);
    end
    tick();
    total++;
    if (A_RVALID !== 1'b0) begin
      bad++; $display("FAIL rb_pulse: A_RVALID=%b required 0", A_RVALID);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    wait_ready();
    A_REQ = 1; A_WE = 1; A_ADDR = 4'd1; A_WDATA = 8'h11;
    B_REQ = 1; B_WE = 1; B_ADDR = 4'd2; B_WDATA = 8'h22;
    tick();
    total++;
    if (A_GNT !== 1'b1 || B_GNT !== 1'b0 || RAM_WR_EN !== 1'b1 || RAM_WR_ADDR !== 4'd1 || RAM_WR_DATA !== 8'h11) begin
      bad++; $display("FAIL cont_first: a=%b b=%b wr=%b addr=%h data=%h required 1 0 1 1 11",
        A_GNT, B_GNT, RAM_WR_EN, RAM_WR_ADDR, RAM_WR_DATA);
    end
    A_REQ = 0;
    tick();
    total++;
    if (A_GNT !== 1'b0 || B_GNT !== 1'b1 || RAM_WR_EN !== 1'b1 || RAM_WR_ADDR !== 4'd2 || RAM_WR_DATA !== 8'h22) begin
      bad++; $display("FAIL cont_second: a=%b b=%b wr=%b addr=%h data=%h required 0 1 1 2 22",
        A_GNT, B_GNT, RAM_WR_EN, RAM_WR_ADDR, RAM_WR_DATA);
    end
    B_REQ = 0;
    tick();
    total++;
    if (B_GNT !== 1'b0 || RAM_WR_EN !== 1'b0) begin
      bad++; $display("FAIL cont_idle: b=%b wr=%b required 0 0", B_GNT, RAM_WR_EN);
    end
  endtask

  task automatic test_fairness();
    logic ea, eb;
    A_REQ = 1; A_WE = 0; A_ADDR = 4'd1;
    B_REQ = 1; B_WE = 0; B_ADDR = 4'd2;
    for (int k = 1; k <= 10; k++) begin
      tick();
      ea = (k % 2 == 1);
      eb = (k % 2 == 0);
      total++;
      if (A_GNT !== ea || B_GNT !== eb || RAM_WR_EN !== 1'b0) begin
        bad++; $display("FAIL fair_gnt: cycle %0d a=%b b=%b wr=%b required %b %b 0", k, A_GNT, B_GNT, RAM_WR_EN, ea, eb);
      end
      if (k >= 2) begin
        total++;
        if (A_RVALID !== eb || B_RVALID !== ea) begin
          bad++; $display("FAIL fair_rvalid: cycle %0d a=%b b=%b required %b %b", k, A_RVALID, B_RVALID, eb, ea);
        end
      end
      if (A_RVALID === 1'b1) begin
        total++;
        if (A_RDATA !== 8'h11) begin
          bad++; $display("FAIL fair_a_data: cycle %0d got %h required 11", k, A_RDATA);
        end
      end
      if (B_RVALID === 1'b1) begin
        total++;
        if (B_RDATA !== 8'h22) begin
          bad++; $display("FAIL fair_b_data: cycle %0d got %h required 22", k, B_RDATA);
        end
      end
    end
    A_REQ = 0; B_REQ = 0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [4];
    int idx = 0;
    int rv_cnt = 0;
    logic eg, ev;
    addrs = '{4'd2, 4'd1, 4'd2, 4'd1};
    B_REQ = 1; B_WE = 0; B_ADDR = addrs[0];
    for (int k = 1; k <= 9; k++) begin
      tick();
      eg = (k % 2 == 1) && (k <= 7);
      ev = (k % 2 == 0) && (k <= 8);
      total++;
      if (B_GNT !== eg || B_RVALID !== ev || A_GNT !== 1'b0) begin
        bad++; $display("FAIL b2b_timing: cycle %0d gnt=%b rvalid=%b a_gnt=%b required %b %b 0",
          k, B_GNT, B_RVALID, A_GNT, eg, ev);
      end
      if (B_RVALID === 1'b1) begin
        rv_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra: cycle %0d RVALID with nothing outstanding", k);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (B_RDATA !== e) begin
            bad++; $display("FAIL b2b_data: cycle %0d got %h required %h", k, B_RDATA, e);
          end
        end
      end
      if (B_GNT === 1'b1) begin
        exp_q.push_back((B_ADDR == 4'd1) ? 8'h11 : 8'h22);
        idx++;
        if (idx < 4) B_ADDR = addrs[idx];
        else B_REQ = 0;
      end
    end
    total++;
    if (rv_cnt != 4 || exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_count: rvalids=%0d left=%0d required 4 0", rv_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_read();
    int late_rv = 0;
    B_REQ = 1; B_WE = 0; B_ADDR = 4'd2;
    tick();
    total++;
    if (B_GNT !== 1'b1 || RAM_RD_EN !== 1'b1) begin
      bad++; $display("FAIL mid_gnt: gnt=%b rd=%b required 1 1", B_GNT, RAM_RD_EN);
    end
    B_REQ = 0;
    #2;
    RST_N = 0;
    #1;
    total++;
    if ({B_GNT, RAM_RD_EN, B_RVALID, READY, DBG_STATE} !== 5'b00000 || RAM_RD_ADDR !== 4'd0) begin
      bad++; $display("FAIL mid_async_clear: ctrl=%b addr=%h required 00000 0",
        {B_GNT, RAM_RD_EN, B_RVALID, READY, DBG_STATE}, RAM_RD_ADDR);
    end
    tick();
    if (B_RVALID !== 1'b0) late_rv++;
    tick();
    if (B_RVALID !== 1'b0) late_rv++;
    RST_N = 1;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (B_RVALID !== 1'b0) late_rv++;
      if (k == 17) begin
        total++;
        if (READY !== 1'b0) begin
          bad++; $display("FAIL mid_ready_early: READY=%b required 0", READY);
        end
      end
    end
    total++;
    if (READY !== 1'b1) begin
      bad++; $display("FAIL mid_ready: READY=%b required 1", READY);
    end
    total++;
    if (late_rv != 0) begin
      bad++; $display("FAIL mid_no_rvalid: B_RVALID pulses=%0d required 0", late_rv);
    end
  endtask

  initial begin
    RST_N = 1;
    idle_clients();
    #2;
    test_reset();
    test_init_hold();
    test_read_back();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
